// File: rtl/spmv_pkg.sv
// Shared SpMV definitions: AXI read constants, default widths and a constant-safe clog2.
package spmv_pkg;

  localparam int DEF_ADDR_WIDTH = 48;
  localparam int DEF_DATA_WIDTH = 32;

  localparam logic [2:0] ARSIZE_4B       = 3'b010;
  localparam logic [1:0] ARBURST_INCR    = 2'b01;
  localparam logic [3:0] ARCACHE_DEFAULT = 4'b0010;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/spmv_pend_fifo.sv
// Pending-entry FIFO: one-cycle write-to-read, pop data read straight from the head slot.
// Push is ignored when full and pop when empty; freeing by a same-cycle pop is not seen by full.
module spmv_pend_fifo
  import spmv_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign pop_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/spmv_x_gather.sv
// SpMV x gather: one 4-byte AXI read per column entry, responses paired in order with held a values.
// One register stage on AR and on pair output; accepts 1 entry/cycle until MAX_OUTSTANDING are pending.
module spmv_x_gather
  import spmv_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH       = 32,
  parameter int ID_WIDTH        = 1,
  parameter int MAX_OUTSTANDING = 16,
  localparam int CNT_W          = clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] x_base,

  input  logic                  s_col_valid,
  output logic                  s_col_ready,
  input  logic [IDX_WIDTH-1:0]  s_col_idx,
  input  logic [DATA_WIDTH-1:0] s_col_aval,
  input  logic                  s_col_last,

  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic                  m_pair_valid,
  input  logic                  m_pair_ready,
  output logic [DATA_WIDTH-1:0] m_pair_aval,
  output logic [DATA_WIDTH-1:0] m_pair_xval,
  output logic                  m_pair_last,
  output logic                  m_pair_err,

  output logic                  orphan_err,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  busy
);

  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  pair_valid_q, pair_valid_d;
  logic [DATA_WIDTH-1:0] pair_aval_q, pair_aval_d;
  logic [DATA_WIDTH-1:0] pair_xval_q, pair_xval_d;
  logic                  pair_last_q, pair_last_d;
  logic                  pair_err_q, pair_err_d;
  logic                  orphan_q, orphan_d;

  logic                  col_hs, ar_hs, r_hs, pair_hs;
  logic                  r_take, r_orphan;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH:0]   push_dat, pop_dat;

  // R beat ID and RLAST carry no information for single-beat in-order reads.
  logic unused_r_sideband;
  assign unused_r_sideband = ^{m_axi_rid, m_axi_rlast};

  assign s_col_ready  = (~arvalid_q | m_axi_arready) & ~fifo_full;
  assign m_axi_rready = ~pair_valid_q | m_pair_ready;

  assign col_hs   = s_col_valid & s_col_ready;
  assign ar_hs    = arvalid_q & m_axi_arready;
  assign r_hs     = m_axi_rvalid & m_axi_rready;
  assign pair_hs  = pair_valid_q & m_pair_ready;
  assign r_take   = r_hs & ~fifo_empty;
  assign r_orphan = r_hs & fifo_empty;
  assign push_dat = {s_col_aval, s_col_last};

  spmv_pend_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend (
    .clk        (clk),
    .rst        (rst),
    .push_i     (col_hs),
    .push_dat_i (push_dat),
    .pop_i      (r_take),
    .pop_dat_o  (pop_dat),
    .count_o    (outstanding),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    if (ar_hs) arvalid_d = 1'b0;
    // Address arithmetic is done at ADDR_WIDTH so it wraps rather than carrying out.
    if (col_hs) begin
      arvalid_d = 1'b1;
      araddr_d  = x_base + (ADDR_WIDTH'(s_col_idx) << 2);
    end
  end

  always_comb begin
    pair_valid_d = pair_valid_q;
    pair_aval_d  = pair_aval_q;
    pair_xval_d  = pair_xval_q;
    pair_last_d  = pair_last_q;
    pair_err_d   = pair_err_q;
    orphan_d     = orphan_q | r_orphan;
    if (pair_hs) pair_valid_d = 1'b0;
    if (r_take) begin
      pair_valid_d = 1'b1;
      pair_aval_d  = pop_dat[DATA_WIDTH:1];
      pair_xval_d  = m_axi_rdata;
      pair_last_d  = pop_dat[0];
      pair_err_d   = (m_axi_rresp != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      pair_valid_q <= 1'b0;
      pair_aval_q  <= '0;
      pair_xval_q  <= '0;
      pair_last_q  <= 1'b0;
      pair_err_q   <= 1'b0;
      orphan_q     <= 1'b0;
    end else begin
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      pair_valid_q <= pair_valid_d;
      pair_aval_q  <= pair_aval_d;
      pair_xval_q  <= pair_xval_d;
      pair_last_q  <= pair_last_d;
      pair_err_q   <= pair_err_d;
      orphan_q     <= orphan_d;
    end
  end

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = ARSIZE_4B;
  assign m_axi_arburst = ARBURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = ARCACHE_DEFAULT;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = arvalid_q;

  assign m_pair_valid = pair_valid_q;
  assign m_pair_aval  = pair_aval_q;
  assign m_pair_xval  = pair_xval_q;
  assign m_pair_last  = pair_last_q;
  assign m_pair_err   = pair_err_q;
  assign orphan_err   = orphan_q;
  assign busy         = (outstanding != '0) | arvalid_q | pair_valid_q;

endmodule

// File: tb/tb_spmv_x_gather.sv
// Randomized and directed checks of spmv_x_gather against a queue-based transaction model.
module tb_spmv_x_gather;
  localparam int AW = 48, DW = 32, IW = 32, IDW = 1, MO = 16, CW = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  x_base;
  logic           s_col_valid, s_col_ready, s_col_last;
  logic [IW-1:0]  s_col_idx;
  logic [DW-1:0]  s_col_aval;
  logic [IDW-1:0] m_axi_arid, m_axi_rid;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize, m_axi_arprot;
  logic [1:0]     m_axi_arburst, m_axi_rresp;
  logic           m_axi_arlock, m_axi_arvalid, m_axi_arready;
  logic [3:0]     m_axi_arcache, m_axi_arqos;
  logic [DW-1:0]  m_axi_rdata;
  logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic           m_pair_valid, m_pair_ready, m_pair_last, m_pair_err;
  logic [DW-1:0]  m_pair_aval, m_pair_xval;
  logic           orphan_err, busy;
  logic [CW-1:0]  outstanding;

  spmv_x_gather #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .ID_WIDTH(IDW),
                  .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .x_base(x_base),
    .s_col_valid(s_col_valid), .s_col_ready(s_col_ready), .s_col_idx(s_col_idx),
    .s_col_aval(s_col_aval), .s_col_last(s_col_last),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_pair_valid(m_pair_valid), .m_pair_ready(m_pair_ready), .m_pair_aval(m_pair_aval),
    .m_pair_xval(m_pair_xval), .m_pair_last(m_pair_last), .m_pair_err(m_pair_err),
    .orphan_err(orphan_err), .outstanding(outstanding), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [DW-1:0] a; logic last; logic [AW-1:0] addr;} ent_t;
  typedef struct packed {logic [DW-1:0] a; logic [DW-1:0] x; logic last; logic err;} pair_t;
  typedef struct packed {logic [IW-1:0] idx; logic [DW-1:0] a; logic last;} scr_t;

  ent_t          pendq[$];
  logic [AW-1:0] arq[$];
  pair_t         pairq[$];
  logic [AW-1:0] memq[$];
  scr_t          scrq[$];
  logic [1:0]    respq[$];
  logic [AW-1:0] ar_log[$];
  int            ar_cyc[$];
  pair_t         p_log[$];
  logic          exp_orphan = 1'b0;

  int n_cmp = 0, n_bad = 0, cyc = 0, n_acc = 0;
  int col_left = 0, col_pct = 0, ar_pct = 0, r_pct = 0, out_pct = 0, err_pct = 0, r_left = 0;
  bit force_orphan = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] xb, input logic [IW-1:0] idx);
    logic [63:0] s;
    s = {16'd0, xb} + {32'd0, idx} * 64'd4;
    return s[AW-1:0];
  endfunction

  // Memory contents as seen by the bench's x-vector slave.
  function automatic logic [DW-1:0] xmem(input logic [AW-1:0] a);
    return a[31:0] ^ {a[47:32], 16'hBEEF};
  endfunction

  task automatic drive();
    s_col_valid = (col_left > 0) && ($urandom_range(99) < col_pct);
    if (scrq.size() > 0) begin
      s_col_idx = scrq[0].idx; s_col_aval = scrq[0].a; s_col_last = scrq[0].last;
    end else begin
      s_col_idx = $urandom; s_col_aval = $urandom; s_col_last = 1'($urandom_range(1));
    end
    m_axi_arready = ($urandom_range(99) < ar_pct);
    m_axi_rvalid  = force_orphan || ((memq.size() > 0) && (r_left > 0) && ($urandom_range(99) < r_pct));
    m_axi_rdata   = (memq.size() > 0) ? xmem(memq[0]) : $urandom;
    if (respq.size() > 0) m_axi_rresp = respq[0];
    else m_axi_rresp = ($urandom_range(99) < err_pct) ? 2'($urandom_range(3, 1)) : 2'b00;
    m_axi_rid    = 1'($urandom);
    m_axi_rlast  = 1'b1;
    m_pair_ready = ($urandom_range(99) < out_pct);
  endtask

  task automatic check_update();
    bit col_hs, ar_hs, r_hs, p_hs;
    ent_t e;
    pair_t p;
    logic [AW-1:0] a;
    col_hs = s_col_valid && s_col_ready;
    ar_hs  = m_axi_arvalid && m_axi_arready;
    r_hs   = m_axi_rvalid && m_axi_rready;
    p_hs   = m_pair_valid && m_pair_ready;
    chk("outstanding", outstanding, pendq.size());
    chk("arvalid", m_axi_arvalid, arq.size() != 0);
    if (arq.size() > 0) chk("araddr", m_axi_araddr, arq[0]);
    chk("pair_valid", m_pair_valid, pairq.size() != 0);
    if (pairq.size() > 0) begin
      chk("pair_aval", m_pair_aval, pairq[0].a);
      chk("pair_xval", m_pair_xval, pairq[0].x);
      chk("pair_last", m_pair_last, pairq[0].last);
      chk("pair_err", m_pair_err, pairq[0].err);
    end
    chk("s_col_ready", s_col_ready, (arq.size() == 0 || m_axi_arready) && pendq.size() < MO);
    chk("rready", m_axi_rready, pairq.size() == 0 || m_pair_ready);
    chk("orphan_err", orphan_err, exp_orphan);
    chk("busy", busy, pendq.size() != 0 || arq.size() != 0 || pairq.size() != 0);
    if (p_hs && pairq.size() > 0) p_log.push_back(pairq.pop_front());
    if (ar_hs) begin
      memq.push_back(m_axi_araddr);
      ar_log.push_back(m_axi_araddr);
      ar_cyc.push_back(cyc);
      if (arq.size() > 0) void'(arq.pop_front());
    end
    if (r_hs) begin
      if (pendq.size() > 0) begin
        e = pendq.pop_front();
        p.a = e.a; p.x = xmem(e.addr); p.last = e.last; p.err = (m_axi_rresp != 2'b00);
        pairq.push_back(p);
      end else exp_orphan = 1'b1;
      if (memq.size() > 0) void'(memq.pop_front());
      if (respq.size() > 0) void'(respq.pop_front());
      if (r_left > 0) r_left--;
    end
    if (col_hs) begin
      a = exp_addr(x_base, s_col_idx);
      e.a = s_col_aval; e.last = s_col_last; e.addr = a;
      pendq.push_back(e);
      arq.push_back(a);
      if (scrq.size() > 0) void'(scrq.pop_front());
      if (col_left > 0) col_left--;
      n_acc++;
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    col_left = 0; ar_pct = 100; r_pct = 100; out_pct = 100; r_left = 1000000; err_pct = 0;
    for (int i = 0; i < 300 && (busy === 1'b1 || memq.size() > 0); i++) cycle();
    chk("drain_busy", busy, 0);
    chk("drain_outstanding", outstanding, 0);
  endtask

  task automatic clear_model();
    pendq.delete(); arq.delete(); pairq.delete(); memq.delete();
    scrq.delete(); respq.delete(); exp_orphan = 1'b0;
  endtask

  initial begin
    scr_t s;
    logic [AW-1:0] a0;
    rst = 1'b1; x_base = '0; s_col_valid = 0; s_col_idx = '0; s_col_aval = '0; s_col_last = 0;
    m_axi_arready = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rid = '0; m_axi_rlast = 0;
    m_axi_rvalid = 0; m_pair_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_pair_valid", m_pair_valid, 0);
    chk("rst_pair_data", {m_pair_aval, m_pair_xval}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_orphan", orphan_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_col_ready", s_col_ready, 1);
    chk("ar_const", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arid},
        {8'd0, 3'b010, 2'b01, 4'b0010, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Four back-to-back entries from base 0x1000, reads held back until all are issued.
    x_base = 48'h1000;
    for (int i = 0; i < 4; i++) begin
      s.idx = i; s.a = 32'h100 + i; s.last = (i == 3); scrq.push_back(s);
    end
    ar_log.delete(); ar_cyc.delete(); p_log.delete();
    col_left = 4; col_pct = 100; ar_pct = 100; r_pct = 0; out_pct = 100; r_left = 1000000;
    repeat (6) cycle();
    chk("seq_ar_count", ar_log.size(), 4);
    for (int i = 0; i < 4 && i < ar_log.size(); i++) begin
      chk("seq_araddr", ar_log[i], 48'h1000 + 4 * i);
      chk("seq_ar_cycle", ar_cyc[i] - ar_cyc[0], i);
    end
    r_pct = 100;
    repeat (8) cycle();
    chk("seq_pair_count", p_log.size(), 4);
    for (int i = 0; i < 4 && i < p_log.size(); i++) begin
      chk("seq_pair_aval", p_log[i].a, 32'h100 + i);
      chk("seq_pair_last", p_log[i].last, i == 3);
    end
    drain();

    // Capacity: with no responses only MAX_OUTSTANDING entries get in.
    n_acc = 0; col_left = 20; col_pct = 100; ar_pct = 100; r_pct = 0; out_pct = 100;
    repeat (24) cycle();
    chk("cap_accepted", n_acc, 16);
    chk("cap_outstanding", outstanding, 16);
    chk("cap_s_col_ready", s_col_ready, 0);
    r_pct = 100; r_left = 1;
    cycle();
    chk("cap_after_r", outstanding, 15);
    r_pct = 0;
    cycle();
    chk("cap_refill_acc", n_acc, 17);
    chk("cap_refill_out", outstanding, 16);
    col_left = 0;

    // Output stall during an R stream: one beat captured, R blocked.
    r_pct = 100; r_left = 1000000; out_pct = 0;
    repeat (6) cycle();
    chk("stall_outstanding", outstanding, 15);
    chk("stall_pair_valid", m_pair_valid, 1);
    chk("stall_rready", m_axi_rready, 0);
    drain();

    // AR stall: address held, input blocked, then 1 entry/cycle.
    n_acc = 0; col_left = 10; col_pct = 100; ar_pct = 0; r_pct = 100; out_pct = 100;
    cycle();
    a0 = arq.size() > 0 ? arq[0] : '1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("arstall_araddr", m_axi_araddr, a0);
      chk("arstall_arvalid", m_axi_arvalid, 1);
      chk("arstall_s_col_ready", s_col_ready, 0);
    end
    ar_pct = 100;
    repeat (9) cycle();
    chk("arstall_resume_acc", n_acc, 10);
    drain();

    // Error response on the second beat only.
    p_log.delete();
    for (int i = 0; i < 2; i++) begin
      s.idx = 7 + i; s.a = 32'hA0 + i; s.last = 1'b0; scrq.push_back(s);
    end
    respq.push_back(2'b00); respq.push_back(2'b10);
    col_left = 2; col_pct = 100;
    repeat (6) cycle();
    drain();
    chk("err_pairs", p_log.size(), 2);
    if (p_log.size() == 2) begin
      chk("err_first", p_log[0].err, 0);
      chk("err_second", p_log[1].err, 1);
    end

    // Address wrap at the top of the address space.
    x_base = 48'hFFFF_FFFF_F000;
    s.idx = 32'h400; s.a = 32'h5; s.last = 1'b1; scrq.push_back(s);
    col_left = 1; col_pct = 100; ar_pct = 0;
    cycle();
    chk("wrap_arvalid", m_axi_arvalid, 1);
    chk("wrap_araddr", m_axi_araddr, 48'h0);
    drain();

    // Orphan beat with nothing pending.
    force_orphan = 1'b1;
    cycle();
    force_orphan = 1'b0;
    repeat (3) cycle();
    chk("orphan_set", orphan_err, 1);
    chk("orphan_no_pair", m_pair_valid, 0);

    // Random traffic.
    x_base = AW'({$urandom, $urandom});
    col_left = 400; col_pct = 70; ar_pct = 60; r_pct = 70; out_pct = 60; err_pct = 20;
    repeat (500) cycle();
    drain();

    // Reset in the middle of traffic.
    col_left = 400; col_pct = 90; ar_pct = 70; r_pct = 40; out_pct = 50;
    repeat (40) cycle();
    rst = 1'b1;
    #1;
    chk("mid_rst_arvalid", m_axi_arvalid, 0);
    chk("mid_rst_pair_valid", m_pair_valid, 0);
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_orphan", orphan_err, 0);
    clear_model();
    s_col_valid = 0; m_axi_rvalid = 0; col_left = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    x_base = AW'({$urandom, $urandom});
    col_left = 100; col_pct = 80; ar_pct = 80; r_pct = 80; out_pct = 80; err_pct = 10;
    repeat (150) cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
